// File: rtl/control_suma_pkg.sv
// Shared types and 7-segment constants for the adder/display sequencing controller.
// Segment codes are active-low with bit order {g,f,e,d,c,b,a}.
package control_suma_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoadB = 2'd1,
    StCalc  = 2'd2,
    StShow  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Element i holds the code for digit i.
  localparam logic [9:0][6:0] SEG_LUT = {
    SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

endpackage

// File: rtl/decodificador_7seg.sv
// BCD digit to active-low 7-segment code; codes above 9 are blanked.
module decodificador_7seg
  import control_suma_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i < 4'd10) begin
      seg_o = SEG_LUT[bcd_i];
    end
  end

endmodule

// File: rtl/control_suma_display.sv
// Load A / load B / registered sum / show controller for the adder lab display.
// Build option ECHO_OPERAND_EN: echo the live switch value on the digits in IDLE and LOAD_B.
module control_suma_display
  import control_suma_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH:0]   S,
  output logic [6:0]       units_seg,
  output logic [6:0]       tens_seg,
  output logic [1:0]       state_o,
  output logic             valid
);

  // Button synchronizers and rising-edge detectors
  logic [1:0] load_sync_q, clear_sync_q;
  logic       load_prev_q, clear_prev_q;
  logic       load_p, clear_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_sync_q  <= 2'b00;
      clear_sync_q <= 2'b00;
      load_prev_q  <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      load_sync_q  <= {load_sync_q[0], btn_load};
      clear_sync_q <= {clear_sync_q[0], btn_clear};
      load_prev_q  <= load_sync_q[1];
      clear_prev_q <= clear_sync_q[1];
    end
  end

  assign load_p  = load_sync_q[1] & ~load_prev_q;
  assign clear_p = clear_sync_q[1] & ~clear_prev_q;

  // Datapath and FSM registers
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   s_q, s_d;
  logic             valid_q, valid_d;
  logic [6:0]       tens_seg_q, tens_seg_d;
  logic [6:0]       units_seg_q, units_seg_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   bcd_val;
  logic [3:0]       tens_val, units_val;
  logic [6:0]       tens_dec, units_dec;
  logic [6:0]       idle_tens, idle_units;

  assign sum_w = {1'b0, a_q} + {1'b0, b_q};

`ifdef ECHO_OPERAND_EN
  logic [WIDTH-1:0] sw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q <= '0;
    end else begin
      sw_q <= sw;
    end
  end

  // The decoders are shared: CALC decodes the sum, every other state the live operand.
  always_comb begin
    bcd_val = sum_w;
    if (state_q != StCalc) begin
      bcd_val = {1'b0, sw_q};
    end
  end

  assign idle_tens  = tens_dec;
  assign idle_units = units_dec;
`else
  assign bcd_val    = sum_w;
  assign idle_tens  = SEG_BLANK;
  assign idle_units = SEG_BLANK;
`endif

  // Binary to tens/units split for values 0..30
  always_comb begin
    tens_val = 4'd0;
    if (bcd_val >= (WIDTH+1)'(30)) begin
      tens_val = 4'd3;
    end else if (bcd_val >= (WIDTH+1)'(20)) begin
      tens_val = 4'd2;
    end else if (bcd_val >= (WIDTH+1)'(10)) begin
      tens_val = 4'd1;
    end
    units_val = 4'(bcd_val - ((WIDTH+1)'(tens_val) * (WIDTH+1)'(10)));
  end

  decodificador_7seg u_dec_units (
    .bcd_i (units_val),
    .seg_o (units_dec)
  );

  decodificador_7seg u_dec_tens (
    .bcd_i (tens_val),
    .seg_o (tens_dec)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    valid_d     = valid_q;
    tens_seg_d  = tens_seg_q;
    units_seg_d = units_seg_q;

    unique case (state_q)
      StIdle: begin
        tens_seg_d  = idle_tens;
        units_seg_d = idle_units;
        if (load_p) begin
          state_d = StLoadB;
          a_d     = sw;
        end
      end
      StLoadB: begin
        tens_seg_d  = idle_tens;
        units_seg_d = idle_units;
        if (load_p) begin
          state_d = StCalc;
          b_d     = sw;
        end
      end
      StCalc: begin
        state_d     = StShow;
        s_d         = sum_w;
        valid_d     = 1'b1;
        tens_seg_d  = tens_dec;
        units_seg_d = units_dec;
      end
      StShow: begin
        if (load_p) begin
          state_d     = StLoadB;
          a_d         = sw;
          valid_d     = 1'b0;
          tens_seg_d  = idle_tens;
          units_seg_d = idle_units;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Clear overrides any simultaneous load.
    if (clear_p) begin
      state_d     = StIdle;
      a_d         = '0;
      b_d         = '0;
      s_d         = '0;
      valid_d     = 1'b0;
      tens_seg_d  = SEG_BLANK;
      units_seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      valid_q     <= 1'b0;
      tens_seg_q  <= SEG_BLANK;
      units_seg_q <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      valid_q     <= valid_d;
      tens_seg_q  <= tens_seg_d;
      units_seg_q <= units_seg_d;
    end
  end

  assign S         = s_q;
  assign valid     = valid_q;
  assign tens_seg  = tens_seg_q;
  assign units_seg = units_seg_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_control_suma_display.sv
// Scoreboard bench for control_suma_display: sums queued at issue, checked when valid rises.
module tb_control_suma_display;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D7 = 7'b1111000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_load, btn_clear;
  logic [4:0] S;
  logic [6:0] units_seg, tens_seg;
  logic [1:0] state_o;
  logic       valid;

  always #5 clk = ~clk;

  control_suma_display #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_clear (btn_clear),
    .S         (S),
    .units_seg (units_seg),
    .tens_seg  (tens_seg),
    .state_o   (state_o),
    .valid     (valid)
  );

  typedef struct packed {
    logic [4:0] s;
    logic [6:0] t;
    logic [6:0] u;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  logic valid_prev = 1'b0;

  function automatic void chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: a rising valid means a fresh sum is being presented.
  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_sum: got S=%0d required no output", S);
      end else begin
        e = exp_q.pop_front();
        chk("sum_S", int'(S), int'(e.s));
        chk("sum_tens", int'(tens_seg), int'(e.t));
        chk("sum_units", int'(units_seg), int'(e.u));
        chk("sum_state", int'(state_o), 3);
      end
    end
    valid_prev <= valid;
  end

  task automatic press(input logic ld, input logic clr);
    btn_load  = ld;
    btn_clear = clr;
    repeat (4) @(negedge clk);
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b,
                    input logic [4:0] s, input logic [6:0] t, input logic [6:0] u);
    sw = a;
    press(1'b1, 1'b0);
    chk("loadA_state", int'(state_o), 1);
    chk("loadA_valid", int'(valid), 0);
`ifndef ECHO_OPERAND_EN
    chk("loadA_tens_blank", int'(tens_seg), int'(BLANK));
    chk("loadA_units_blank", int'(units_seg), int'(BLANK));
`endif
    sw = b;
    exp_q.push_back('{s: s, t: t, u: u});
    press(1'b1, 1'b0);
    chk("show_state", int'(state_o), 3);
    chk("show_valid", int'(valid), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    sw        = 4'd0;
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", int'(state_o), 0);
    chk("rst_S", int'(S), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_tens", int'(tens_seg), int'(BLANK));
    chk("rst_units", int'(units_seg), int'(BLANK));
    rst = 1'b0;
    @(negedge clk);

    op(4'd15, 4'd10, 5'd25, D2, D5);
    op(4'd7, 4'd5, 5'd12, D1, D2);

    // Switch changes after capture must not disturb the held sum.
    sw = 4'd9;
    repeat (3) @(negedge clk);
    chk("hold_S", int'(S), 12);

    sw = 4'd1;
    press(1'b1, 1'b0);
    chk("reload_state", int'(state_o), 1);
    chk("reload_valid", int'(valid), 0);
`ifndef ECHO_OPERAND_EN
    chk("reload_tens", int'(tens_seg), int'(BLANK));
    chk("reload_units", int'(units_seg), int'(BLANK));
`endif

    // Load and clear together: clear wins.
    press(1'b1, 1'b1);
    chk("clr_state", int'(state_o), 0);
    chk("clr_S", int'(S), 0);
    chk("clr_valid", int'(valid), 0);
`ifndef ECHO_OPERAND_EN
    chk("clr_tens", int'(tens_seg), int'(BLANK));
    chk("clr_units", int'(units_seg), int'(BLANK));
`else
    sw = 4'd12;
    repeat (2) @(negedge clk);
    chk("echo_tens", int'(tens_seg), int'(D1));
    chk("echo_units", int'(units_seg), int'(D2));
`endif

    // Held button produces a single pulse: stays in LOAD_B with A=3.
    sw       = 4'd3;
    btn_load = 1'b1;
    repeat (20) @(negedge clk);
    chk("hold_btn_state", int'(state_o), 1);
    btn_load = 1'b0;
    repeat (4) @(negedge clk);
    sw = 4'd4;
    exp_q.push_back('{s: 5'd7, t: D0, u: D7});
    press(1'b1, 1'b0);
    chk("hold_btn_show", int'(state_o), 3);

    op(4'd0, 4'd0, 5'd0, D0, D0);
    op(4'd15, 4'd15, 5'd30, D3, D0);
    op(4'd5, 4'd5, 5'd10, D1, D0);

    // Reset in the middle of an operation.
    sw = 4'd2;
    press(1'b1, 1'b0);
    chk("mid_loadB", int'(state_o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_S", int'(S), 0);
    chk("midrst_valid", int'(valid), 0);

    // A pulse still inside the synchronizer is dropped by reset.
    btn_load = 1'b1;
    @(negedge clk);
    rst      = 1'b1;
    btn_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("inflight_state", int'(state_o), 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_suma_display.md
# control_suma_display

Sequencing controller for the 4-bit adder/display lab datapath. It captures operand A and then operand B from the board switches on successive presses of a load button. It computes the 5-bit sum in a registered CALC step and holds the result on two 7-segment digits (tens, units) until the next load or a clear. It sits between the board I/O (switches, push-buttons, HEX displays) and the adder/BCD logic.

## Interface
Parameters:
- WIDTH, 4, operand width; result width is WIDTH+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sw  in  WIDTH  operand value from the switches.
- btn_load  in  1  asynchronous level from the load button, active-high.
- btn_clear  in  1  asynchronous level from the clear button, active-high.
- S  out  WIDTH+1  registered sum A+B.
- units_seg  out  7  units digit, active-low, bit order {g,f,e,d,c,b,a}.
- tens_seg  out  7  tens digit, same encoding.
- state_o  out  2  current state: IDLE=0, LOAD_B=1, CALC=2, SHOW=3.
- valid  out  1  high while S and both digits hold a completed sum.

## Operation
- Each button goes through a 2-FF synchronizer and then a rising-edge detector, giving one single-cycle pulse per press (load_p, clear_p).
- IDLE → LOAD_B on load_p: A_reg ← sw.
- LOAD_B → CALC on load_p: B_reg ← sw.
- CALC → SHOW unconditionally after 1 cycle: S ← A_reg + B_reg, zero-extended to WIDTH+1 with no truncation; valid ← 1.
- SHOW → LOAD_B on load_p: A_reg ← sw and valid ← 0. This starts a new operation directly.
- clear_p in any state:
  - state ← IDLE; A_reg, B_reg, S ← 0; valid ← 0; digits blank.
- Simultaneous load_p and clear_p: clear wins.
- BCD split of S (range 0–30): tens ∈ {0,1,2,3}, units = S − 10·tens. A tens value of 0 is displayed as '0', not blanked.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Outside SHOW, both digits are blank unless ECHO_OPERAND_EN is defined (see Configuration).

## Timing
- Reset values: state_o=0 (IDLE), S=0, valid=0, units_seg=tens_seg=1111111. Synchronizer and edge-detect flops are also reset to 0.
- Button latency: a press stable before edge k gives load_p high during cycle k+1. The register capture happens at edge k+2.
- Holding a button generates exactly one pulse; the button must be released and pressed again for the next pulse.
- Sum latency: S, digits and valid update on the same edge that enters SHOW, one edge after B is captured.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation: on the next edge, everything returns to reset values and any in-flight pulse is discarded.
- Changing sw after capture has no effect on A_reg or B_reg.
- Minimum press-to-press spacing: 3 cycles. Closer presses are merged by the synchronizer, not queued.

## Configuration
- ECHO_OPERAND_EN defined: in IDLE and LOAD_B, the digits show the live sw value split into tens/units (0–15). This is combinational from the synchronized sw, registered to the outputs with 1-cycle latency. In CALC, the digits hold their previous value.
- ECHO_OPERAND_EN undefined: digits are blank in IDLE, LOAD_B and CALC.
- S, valid and state_o behave identically in both builds.

## Structure
- Shared package control_suma_pkg:
  - state enum (IDLE, LOAD_B, CALC, SHOW);
  - SEG_BLANK constant;
  - digit-to-segment lookup constants.
- One sub-module: decodificador_7seg (4-bit BCD → 7-bit active-low segments), instantiated twice (units, tens). Inputs above 9 produce SEG_BLANK.
- The synchronizer, edge detect, FSM, sum register and BCD split stay in the top module.

## Test plan
- Reset: assert rst for 2 cycles → state_o=0, S=00000, valid=0, both digits 1111111.
- sw=1111, press load; sw=1010, press load → after CALC: S=11001 (25), tens_seg=0100100, units_seg=0010010, valid=1, state_o=3.
- sw=0111 then sw=0101 → S=01100, tens_seg=1111001, units_seg=0100100. Then press load again with sw=0001 → state_o=1, valid=0, digits blank.
- Hold btn_load high for 20 cycles in IDLE → exactly one transition to LOAD_B, with A captured once.
- Press load and clear in the same cycle from LOAD_B → IDLE, S=0, valid=0.
- ECHO_OPERAND_EN build, sw=1100 in IDLE → 2 cycles after the sw change (after synchronization): tens_seg=1111001, units_seg=0100100.
